// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store unit between the CPU data port and a byte-enabled
// data BRAM. Accepts one request per handshake, positions store data on byte
// lanes, splits misaligned word/half accesses into two word-aligned beats,
// reassembles and extends load data, and returns one registered response.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, split-class
// requests are not issued to memory and instead return rsp_err_o=1.
module data_mem_lsu #(
  parameter int MEM_LATENCY = 1  // BRAM read latency, 1 or 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  // Cycle index (relative to ACC0) at which beat-0 read data is on mem_rdata_i.
  localparam logic [1:0] LatCyc = 2'(MEM_LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic        we_q, uns_q, split_q;
  logic [1:0]  size_q, cyc_q;
  logic [31:0] addr_q, wdata_q, beat0_q;
  logic [31:0] mem_addr_q, mem_wdata_q, rsp_rdata_q;
  logic [3:0]  mem_we_q;
  logic        rsp_valid_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        rsp_err_q;
`endif

  // Request fields: live inputs while accepting in IDLE, latched copy afterwards.
  logic [1:0]  sel_size, sel_k;
  logic [31:0] sel_wdata;
  logic [3:0]  lane_mask;
  logic [7:0]  we8_d;
  logic [63:0] wide_d, combined;
  logic [31:0] beat0_wdata_d, aligned, rdata_d;
  logic [1:0]  last_cyc;
  logic        split_d;

  // Lane decode for stores and reassembly/extension for loads.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    sel_size  = (state_q == S_IDLE) ? req_size_i       : size_q;
    sel_k     = (state_q == S_IDLE) ? req_addr_i[1:0]  : addr_q[1:0];
    sel_wdata = (state_q == S_IDLE) ? req_wdata_i      : wdata_q;

    // Reserved size 11 behaves as a word.
    case (sel_size)
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
    // Low nibble is beat 0's enables, high nibble spills into beat 1.
    we8_d   = {4'b0000, lane_mask} << sel_k;
    wide_d  = {32'h0, sel_wdata} << {sel_k, 3'b000};
    split_d = (sel_size[1] && sel_k != 2'd0) || (sel_size == 2'b01 && sel_k == 2'd3);

    beat0_wdata_d = wide_d[31:0];
    if (sel_size == 2'b00)                 beat0_wdata_d = {4{sel_wdata[7:0]}};
    else if (sel_size == 2'b01 && !split_d) beat0_wdata_d = {2{sel_wdata[15:0]}};

    // For a split load the current read data is beat 1; otherwise it is beat 0.
    combined = split_q ? {mem_rdata_i, beat0_q} : {32'h0, mem_rdata_i};
    aligned  = combined[{addr_q[1:0], 3'b000} +: 32];
    case (size_q)
      2'b00:   rdata_d = uns_q ? {24'h0, aligned[7:0]}  : {{24{aligned[7]}}, aligned[7:0]};
      2'b01:   rdata_d = uns_q ? {16'h0, aligned[15:0]} : {{16{aligned[15]}}, aligned[15:0]};
      default: rdata_d = aligned;
    endcase

    last_cyc = split_q ? LatCyc + 2'd1 : LatCyc;
  end

  // Control FSM with registered memory-side and response-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      split_q     <= 1'b0;
      size_q      <= 2'b00;
      cyc_q       <= 2'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      beat0_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      mem_we_q    <= 4'b0000;
      rsp_valid_q <= 1'b0;
      cyc_q       <= cyc_q + 2'd1;
      if ((state_q == S_ACC1 || state_q == S_WAIT) && cyc_q == LatCyc)
        beat0_q <= mem_rdata_i;

      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            size_q  <= req_size_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            split_q <= split_d;
            cyc_q   <= 2'd0;
            if (!(TrapEn && split_d)) begin
              mem_addr_q  <= {req_addr_i[31:2], 2'b00};
              mem_we_q    <= req_we_i ? we8_d[3:0] : 4'b0000;
              mem_wdata_q <= beat0_wdata_d;
            end
            state_q <= S_ACC0;
          end
        end
        S_ACC0: begin
          if (TrapEn && split_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_q   <= 1'b1;
`endif
            state_q     <= S_RESP;
          end else if (split_q) begin
            mem_addr_q  <= mem_addr_q + 32'd4;
            mem_we_q    <= we_q ? we8_d[7:4] : 4'b0000;
            mem_wdata_q <= wide_d[63:32];
            state_q     <= S_ACC1;
          end else if (we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 32'h0;
            state_q     <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_ACC1: begin
          if (we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 32'h0;
            state_q     <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cyc_q == last_cyc) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
`ifdef LSU_MISALIGN_TRAP_EN
          rsp_err_q <= 1'b0;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Every output reads 0 while reset is high; this also blocks writes during reset.
  assign req_ready_o = (state_q == S_IDLE) && !reset;
  assign rsp_valid_o = rsp_valid_q && !reset;
  assign rsp_rdata_o = reset ? 32'h0 : rsp_rdata_q;
  assign mem_addr_o  = reset ? 32'h0 : mem_addr_q;
  assign mem_we_o    = mem_we_q & {4{~reset}};
  assign mem_wdata_o = reset ? 32'h0 : mem_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_err_o   = rsp_err_q && !reset;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: directed bench for data_mem_lsu. Two instances share the
// request stimulus, one with MEM_LATENCY=1 and one with MEM_LATENCY=2, each
// backed by its own byte-enabled BRAM model.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        ready1, rsp_valid1, err1, ready2, rsp_valid2, err2;
  logic [31:0] rdata1, maddr1, mwdata1, mrdata1, rdata2, maddr2, mwdata2, mrdata2;
  logic [3:0]  mwe1, mwe2;

  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] rd1_p1, rd2_p1, rd2_p2;
  int          rsp_cnt1 = 0, rsp_cnt2 = 0;

  int total = 0, bad = 0;

  // Per-transaction observations.
  int          lat1, lat2, np1, np2;
  logic [31:0] rsp1, rsp2;
  logic        er1, er2, busy1;
  logic [3:0]  bw [1:2];
  logic [31:0] ba [1:2];
  logic [31:0] bd [1:2];
  int          snap1, snap2;

  always #5 clk = ~clk;

  data_mem_lsu #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(ready1), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid1), .rsp_rdata_o(rdata1), .rsp_err_o(err1),
    .mem_addr_o(maddr1), .mem_we_o(mwe1), .mem_wdata_o(mwdata1),
    .mem_rdata_i(mrdata1)
  );

  data_mem_lsu #(.MEM_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(ready2), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid2), .rsp_rdata_o(rdata2), .rsp_err_o(err2),
    .mem_addr_o(maddr2), .mem_we_o(mwe2), .mem_wdata_o(mwdata2),
    .mem_rdata_i(mrdata2)
  );

  // BRAM models: read-first, 1 and 2 cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mwe1[b]) mem1[maddr1[9:2]][8*b +: 8] <= mwdata1[8*b +: 8];
      if (mwe2[b]) mem2[maddr2[9:2]][8*b +: 8] <= mwdata2[8*b +: 8];
    end
    rd1_p1 <= mem1[maddr1[9:2]];
    rd2_p1 <= mem2[maddr2[9:2]];
    rd2_p2 <= rd2_p1;
    if (rsp_valid1) rsp_cnt1 <= rsp_cnt1 + 1;
    if (rsp_valid2) rsp_cnt2 <= rsp_cnt2 + 1;
  end
  assign mrdata1 = rd1_p1;
  assign mrdata2 = rd2_p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request to both instances and watch 10 cycles after acceptance.
  // Cycle i below is T+i where T is the accept cycle.
  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat1 = 0; lat2 = 0; np1 = 0; np2 = 0;
    rsp1 = 'x; rsp2 = 'x; er1 = 1'bx; er2 = 1'bx; busy1 = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid = 1'b0;
        busy1 = ready1;
      end
      if (i <= 2) begin
        bw[i] = mwe1; ba[i] = maddr1; bd[i] = mwdata1;
      end
      if (rsp_valid1) begin
        np1++;
        if (lat1 == 0) begin lat1 = i; rsp1 = rdata1; er1 = err1; end
      end
      if (rsp_valid2) begin
        np2++;
        if (lat2 == 0) begin lat2 = i; rsp2 = rdata2; er2 = err2; end
      end
    end
  endtask

  task automatic check_rsp(input string tag, input int l1, input int l2,
                           input logic [31:0] exp_rd, input logic exp_err);
    check({tag, "_lat1"},  lat1, l1);
    check({tag, "_lat2"},  lat2, l2);
    check({tag, "_pulses1"}, np1, 1);
    check({tag, "_pulses2"}, np2, 1);
    check({tag, "_rdata1"}, rsp1, exp_rd);
    check({tag, "_rdata2"}, rsp2, exp_rd);
    check({tag, "_err1"}, {31'h0, er1}, {31'h0, exp_err});
    check({tag, "_busy"}, {31'h0, busy1}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem1[i] = 32'h0; mem2[i] = 32'h0; end
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready1", {31'h0, ready1}, 32'h0);
    check("rst_ready2", {31'h0, ready2}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid1}, 32'h0);
    check("rst_mem_we", {28'h0, mwe1}, 32'h0);
    check("rst_mem_addr", maddr1, 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_ready1", {31'h0, ready1}, 32'h1);
    check("post_rst_ready2", {31'h0, ready2}, 32'h1);

    // 1: aligned word store and load
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("t1_st_we", {28'h0, bw[1]}, 32'hF);
    check("t1_st_addr", ba[1], 32'h10);
    check("t1_st_data", bd[1], 32'hDEADBEEF);
    check("t1_st_we_after", {28'h0, bw[2]}, 32'h0);
    check_rsp("t1_st", 2, 2, 32'h0, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("t1_ld_we", {28'h0, bw[1]}, 32'h0);
    check_rsp("t1_ld", 3, 4, 32'hDEADBEEF, 1'b0);

    // 2: byte store, signed and unsigned byte loads
    xact(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080);
    check("t2_st_we", {28'h0, bw[1]}, 32'h8);
    check("t2_st_addr", ba[1], 32'h10);
    check("t2_st_data", bd[1], 32'h80808080);
    check_rsp("t2_st", 2, 2, 32'h0, 1'b0);
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check_rsp("t2_lds", 3, 4, 32'hFFFFFF80, 1'b0);
    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check_rsp("t2_ldu", 3, 4, 32'h00000080, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    // 6: misaligned word load traps without touching memory
    xact(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
    check("t6_we", {28'h0, bw[1]}, 32'h0);
    check_rsp("t6_trap", 2, 2, 32'h0, 1'b1);
    xact(1'b1, 2'b10, 1'b0, 32'h21, 32'h11223344);
    check("t6_st_we0", {28'h0, bw[1]}, 32'h0);
    check("t6_st_we1", {28'h0, bw[2]}, 32'h0);
    check_rsp("t6_st_trap", 2, 2, 32'h0, 1'b1);
`else
    // 3: split word store and load
    xact(1'b1, 2'b10, 1'b0, 32'h21, 32'h11223344);
    check("t3_b0_addr", ba[1], 32'h20);
    check("t3_b0_we", {28'h0, bw[1]}, 32'hE);
    check("t3_b0_data", bd[1], 32'h22334400);
    check("t3_b1_addr", ba[2], 32'h24);
    check("t3_b1_we", {28'h0, bw[2]}, 32'h1);
    check("t3_b1_data", bd[2], 32'h00000011);
    check_rsp("t3_st", 3, 3, 32'h0, 1'b0);
    xact(1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
    check_rsp("t3_ld", 4, 5, 32'h11223344, 1'b0);

    // 4: split half across the top of the address space
    xact(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0000A5C3);
    check("t4_b0_addr", ba[1], 32'hFFFFFFFC);
    check("t4_b0_we", {28'h0, bw[1]}, 32'h8);
    check("t4_b0_lane3", {24'h0, bd[1][31:24]}, 32'hC3);
    check("t4_b1_addr", ba[2], 32'h0);
    check("t4_b1_we", {28'h0, bw[2]}, 32'h1);
    check("t4_b1_lane0", {24'h0, bd[2][7:0]}, 32'hA5);
    check_rsp("t4_st", 3, 3, 32'h0, 1'b0);
    xact(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
    check_rsp("t4_ld", 4, 5, 32'hFFFFA5C3, 1'b0);

    // 5: reset during ACC1 of a split store
    snap1 = rsp_cnt1; snap2 = rsp_cnt2;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h31; req_wdata = 32'h55667788;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("t5_acc0_we", {28'h0, mwe1}, 32'hE);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t5_rst_we1", {28'h0, mwe1}, 32'h0);
    check("t5_rst_we2", {28'h0, mwe2}, 32'h0);
    check("t5_rst_ready", {31'h0, ready1}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_ready1", {31'h0, ready1}, 32'h1);
    check("t5_ready2", {31'h0, ready2}, 32'h1);
    repeat (8) @(negedge clk);
    check("t5_no_rsp1", rsp_cnt1 - snap1, 32'h0);
    check("t5_no_rsp2", rsp_cnt2 - snap2, 32'h0);
    check("t5_beat0_mem1", mem1[12], 32'h66778800);
    check("t5_no_beat1_mem1", mem1[13], 32'h0);
    check("t5_no_beat1_mem2", mem2[13], 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Load/store unit between the CPU data port and the byte-enabled data BRAM.
- Accepts one load or store per handshake.
- Generates byte-lane write enables and shifted write data.
- Splits misaligned word/half accesses into two word-aligned BRAM beats.
- Reassembles and sign/zero-extends load data, then returns a single registered response to the CPU.

Parameters:
MEM_LATENCY, 1, BRAM read latency in cycles (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE); only 1 and 2 legal.

Ports:
clk  in  1  clock; all logic rising-edge.
reset  in  1  synchronous, active-high reset.
req_valid_i  in  1  CPU request valid.
req_ready_o  out  1  LSU can accept a request; high only in IDLE.
req_we_i  in  1  1 = store, 0 = load.
req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
req_unsigned_i  in  1  load zero-extend (1) / sign-extend (0).
req_addr_i  in  32  byte address.
req_wdata_i  in  32  store data, right-aligned.
rsp_valid_o  out  1  one-cycle response pulse; consumer always accepts.
rsp_rdata_o  out  32  extended load data; 0 for stores.
rsp_err_o  out  1  misaligned-trap flag (see Optional Feature).
mem_addr_o  out  32  word-aligned byte address to BRAM; bits [1:0] always 0.
mem_we_o  out  4  byte write enables, bit i = byte lane i (little endian).
mem_wdata_o  out  32  lane-positioned write data.
mem_rdata_i  in  32  BRAM read data, valid MEM_LATENCY cycles after address.

Behaviour:
- Reset: state IDLE; all outputs are 0 (including req_ready_o) while reset is high.
  - mem_we_o is gated by ~reset, so no write occurs during reset.
  - Reset mid-operation aborts: a pending second store beat is not issued, and no response is produced.
- States and transitions:
  - IDLE: req_ready_o=1; on req_valid_i latch the request, then go to ACC0.
  - ACC0: drive beat 0; go to ACC1 if split, else WAIT (load) or RESP (store).
  - ACC1: drive beat 1 (address = beat 0 address + 4, 32-bit wrap, so 0xFFFFFFFC+4 = 0x0); go to WAIT (load) or RESP (store).
  - WAIT: loads only; MEM_LATENCY cycles after the last beat.
  - RESP: rsp_valid_o=1 for exactly one cycle; go to IDLE.
- Definitions: k = addr[1:0]. Split when (size=word and k!=0) or (size=half and k=3).
- mem_addr_o = {addr[31:2],2'b00} in ACC0 / ACC1; hold last value otherwise. mem_we_o=0 outside store ACC0/ACC1.
- Store lanes:
  - byte: we = 0001<<k; wdata = byte replicated ×4.
  - half, k<3: we = 0011<<k; wdata = half replicated ×2.
  - word, aligned: we = 1111; wdata = wdata.
  - split word, beat0: we = (1111<<k)[3:0]; data = wdata<<8k.
  - split word, beat1: we = 1111>>(4−k); data = wdata>>8(4−k).
  - half, k=3: beat0 we = 1000 with lane3 = wdata[7:0]; beat1 we = 0001 with lane0 = wdata[15:8].
- Load capture:
  - beat0 data is captured MEM_LATENCY cycles after ACC0; beat1 data MEM_LATENCY cycles after ACC1.
  - combined = {beat1, beat0} >> 8k; take 8/16/32 bits and extend per req_unsigned_i.
  - rsp_rdata_o is registered and presented only in RESP.
- Latency (T = accept cycle, beats = 1 or 2):
  - loads: rsp_valid_o at T+1+beats+MEM_LATENCY.
  - stores: rsp_valid_o at T+1+beats.
- Throughput: req_ready_o is low from T+1 through the RESP cycle; the next accept is the cycle after RESP. A req_valid_i held during busy is ignored, not lost by the LSU.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: split-class requests issue no BRAM access (mem_we_o stays 0). Go ACC0→RESP with rsp_valid_o and rsp_err_o=1 at T+2, rsp_rdata_o=0. Aligned requests are unchanged and have rsp_err_o=0.
- Undefined: requests are split as above; rsp_err_o is tied to 0.

Test Plan:
1. Reset, then aligned store word 0xDEADBEEF @0x10 and load word @0x10, MEM_LATENCY=1 -> store: mem_we_o=1111, mem_addr_o=0x10, rsp at T+2; load: rsp_rdata_o=0xDEADBEEF at T+3.
2. Store byte 0x80 @0x13, then load byte signed and unsigned @0x13 -> mem_we_o=1000, mem_wdata_o=0x80808080; loads return 0xFFFFFF80 and 0x00000080.
3. Store word 0x11223344 @0x21 -> beat0 addr 0x20, we=1110, data=0x22334400; beat1 addr 0x24, we=0001, data=0x00000011; load word @0x21 returns 0x11223344 at T+4 (MEM_LATENCY=1) and T+5 (MEM_LATENCY=2).
4. Store half 0xA5C3 @0xFFFFFFFF -> beat0 addr 0xFFFFFFFC, we=1000; beat1 addr 0x00000000, we=0001; signed half load returns 0xFFFFA5C3.
5. Assert reset in ACC1 of a split store -> no beat1 write; no rsp_valid_o; req_ready_o=1 the cycle after reset deasserts.
6. With LSU_MISALIGN_TRAP_EN: load word @0x2 -> no memory write; rsp_valid_o and rsp_err_o=1 at T+2, rsp_rdata_o=0.
